// File: rtl/ghr_index_gen_if.sv
// Fetch/resolve bus for ghr_index_gen.
// The master drives the fetch and resolve inputs and sees the PHT index,
// the stall and the PHT update port. The slave is the index generator.
interface ghr_index_gen_if #(
    parameter int INDEX_WIDTH = 8
);
    // Fetch side
    logic                   fetch_valid_i;
    logic                   fetch_is_br_i;
    logic [31:0]            fetch_pc_i;
    logic                   pred_taken_i;
    logic [INDEX_WIDTH-1:0] rd_index_o;
    logic                   stall_o;

    // Resolve side
    logic                   resolve_valid_i;
    logic                   resolve_taken_i;
    logic                   resolve_mispredict_i;

    // PHT update port and status
    logic                   update_en_o;
    logic [INDEX_WIDTH-1:0] update_index_o;
    logic                   br_taken_o;
    logic                   err_o;

    modport master (
        output fetch_valid_i, fetch_is_br_i, fetch_pc_i, pred_taken_i,
        output resolve_valid_i, resolve_taken_i, resolve_mispredict_i,
        input  rd_index_o, stall_o, update_en_o, update_index_o, br_taken_o, err_o
    );

    modport slave (
        input  fetch_valid_i, fetch_is_br_i, fetch_pc_i, pred_taken_i,
        input  resolve_valid_i, resolve_taken_i, resolve_mispredict_i,
        output rd_index_o, stall_o, update_en_o, update_index_o, br_taken_o, err_o
    );
endinterface

// File: rtl/ghr_index_gen.sv
// Gshare index generator with a speculative global history register.
// Each fetched conditional branch gets a PHT index (PC bits XOR history),
// and the index plus a history snapshot are queued until the branch
// resolves in order. A resolve pops the oldest entry and drives the PHT
// update; a mispredict restores the history from the snapshot and flushes
// every younger entry.
// Build option: define PHT_UPDATE_REG_EN to register the PHT update port
// (one cycle after the pop edge); otherwise it is driven in the pop cycle.
// Note: rst_ni is active-high despite its name.
module ghr_index_gen #(
    parameter int INDEX_WIDTH = 8,
    parameter int HIST_WIDTH  = 8,
    parameter int DEPTH       = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    ghr_index_gen_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0]       ptr_t;
    typedef logic [CNT_W-1:0]       cnt_t;
    typedef logic [INDEX_WIDTH-1:0] idx_t;
    typedef logic [HIST_WIDTH-1:0]  hist_t;

    // In-flight branch storage
    idx_t  idx_mem  [DEPTH];
    hist_t snap_mem [DEPTH];

    hist_t ghr_q, ghr_d;
    ptr_t  wr_ptr_q, wr_ptr_d;
    ptr_t  rd_ptr_q, rd_ptr_d;
    cnt_t  count_q, count_d;
    logic  err_q, err_d;

    logic  full, empty, kill, push, pop, flush;
    idx_t  ghr_ext, rd_index;
    logic  [HIST_WIDTH:0] spec_cat, recover_cat;

    logic  upd_en_c, upd_tk_c;
    idx_t  upd_idx_c;

    logic  unused_pc;

    // Only the index-forming PC bits matter.
    assign unused_pc = ^{bus.fetch_pc_i[31:INDEX_WIDTH+2], bus.fetch_pc_i[1:0]};

    // Control decode, index formation and PHT update values for this cycle.
    always_comb begin
        full     = (count_q == cnt_t'(DEPTH));
        empty    = (count_q == '0);
        kill     = bus.resolve_valid_i & bus.resolve_mispredict_i;
        pop      = bus.resolve_valid_i & ~empty;
        flush    = pop & bus.resolve_mispredict_i;
        // A correct pop frees the head slot in the same edge, so a full
        // queue still accepts the branch.
        push     = bus.fetch_valid_i & bus.fetch_is_br_i & (~full | pop) & ~kill;

        ghr_ext  = '0;
        ghr_ext[HIST_WIDTH-1:0] = ghr_q;
        rd_index = bus.fetch_pc_i[INDEX_WIDTH+1:2] ^ ghr_ext;

        // Low HIST_WIDTH bits of {history, new bit} are the shifted history;
        // with HIST_WIDTH=1 this degenerates to the new bit alone.
        spec_cat    = {ghr_q, bus.pred_taken_i};
        recover_cat = {snap_mem[rd_ptr_q], bus.resolve_taken_i};

        upd_en_c  = pop;
        upd_idx_c = pop ? idx_mem[rd_ptr_q] : '0;
        upd_tk_c  = pop & bus.resolve_taken_i;
    end

    // Next-state for history, pointers, occupancy and the error flag.
    always_comb begin
        ghr_d    = ghr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (bus.resolve_valid_i & empty);

        if (flush) begin
            ghr_d    = recover_cat[HIST_WIDTH-1:0];
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
            wr_ptr_d = rd_ptr_q + ptr_t'(1);
            count_d  = '0;
        end else begin
            if (push) begin
                ghr_d    = spec_cat[HIST_WIDTH-1:0];
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // State registers with asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            ghr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            ghr_q    <= ghr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Queue write of the branch index and its history snapshot.
    // NOTE: the storage array has no reset; entries are only read while the
    // occupancy count says they are valid, so reset stays on the small state.
    always_ff @(posedge clk_i) begin
        if (push) begin
            idx_mem[wr_ptr_q]  <= rd_index;
            snap_mem[wr_ptr_q] <= ghr_q;
        end
    end

`ifdef PHT_UPDATE_REG_EN
    // Registered PHT update port: strobe appears one cycle after the pop edge.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            bus.update_en_o    <= 1'b0;
            bus.update_index_o <= '0;
            bus.br_taken_o     <= 1'b0;
        end else begin
            bus.update_en_o    <= upd_en_c;
            bus.update_index_o <= upd_idx_c;
            bus.br_taken_o     <= upd_tk_c;
        end
    end
`else
    // Combinational PHT update port: strobe appears in the pop cycle.
    always_comb begin
        bus.update_en_o    = upd_en_c;
        bus.update_index_o = upd_idx_c;
        bus.br_taken_o     = upd_tk_c;
    end
`endif

    assign bus.rd_index_o = rd_index;
    assign bus.stall_o    = full;
    assign bus.err_o      = err_q;

endmodule
